// File: rtl/cpu_stk_pkg.sv
// Shared decode types for cpu_stk: opcode/source enums, field positions and
// the instruction-word decoder.
package cpu_stk_pkg;
  typedef enum logic [2:0] {
    OP_NOP, OP_ALU, OP_ALU_WD, OP_ALU_AD, OP_JMP, OP_CALL, OP_RET, OP_HALT
  } op_e;

  typedef enum logic [1:0] {SX_ACC, SX_ADDR, SX_PC, SX_WDATA} srcx_e;

  localparam int F_IMM  = 0;
  localparam int F_FN   = 8;
  localparam int F_SRCX = 16;
  localparam int F_SRCY = 18;
  localparam int F_WR   = 19;
  localparam int F_RSEL = 20;
  localparam int F_COND = 24;
  localparam int F_OP   = 27;

  typedef struct packed {
    op_e        op;
    logic [2:0] cond;
    logic [1:0] rsel;
    logic       wr;
    logic       src_y;
    srcx_e      src_x;
    logic [7:0] fn;
    logic [7:0] imm;
  } inst_t;

  function automatic inst_t decode(input logic [31:0] i);
    inst_t d;
    d.op    = op_e'(i[F_OP +: 3]);
    d.cond  = i[F_COND +: 3];
    d.rsel  = i[F_RSEL +: 2];
    d.wr    = i[F_WR];
    d.src_y = i[F_SRCY];
    d.src_x = srcx_e'(i[F_SRCX +: 2]);
    d.fn    = i[F_FN +: 8];
    d.imm   = i[F_IMM +: 8];
    return d;
  endfunction
endpackage

// File: rtl/alu.sv
// Function-coded ALU: optional zero/invert on each operand, add or AND,
// then optional shift-left, bit reversal and inversion of the result.
module alu #(
  parameter int MSB = 7
) (
  input  logic [MSB:0] x_i,
  input  logic [MSB:0] y_i,
  input  logic [7:0]   f_i,
  output logic [MSB:0] z_o
);
  logic [MSB:0] xa, ya, s, sh, rb;

  always_comb begin
    xa = f_i[1] ? '0 : x_i;
    xa = f_i[3] ? ~xa : xa;
    ya = f_i[0] ? '0 : y_i;
    ya = f_i[2] ? ~ya : ya;
    s  = f_i[4] ? xa + ya : xa & ya;
    sh = f_i[5] ? s << 1 : s;
    rb = '0;
    for (int k = 0; k <= MSB; k++) rb[k] = sh[MSB-k];
    z_o = f_i[6] ? rb : sh;
    z_o = f_i[7] ? ~z_o : z_o;
  end
endmodule

// File: rtl/cpu_stk_call_stack.sv
// Return-address LIFO. Push when full and pop when empty are ignored; the
// core turns those cases into fault bits.
module call_stack #(
  parameter int PW     = 8,
  parameter int SDEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [PW-1:0] din_i,
  output logic [PW-1:0] top_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int SPW = $clog2(SDEPTH + 1);
  localparam int IW  = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  logic [SDEPTH-1:0][PW-1:0] mem_q;
  logic [SPW-1:0]            sp_q;
  logic [IW-1:0]             wr_idx, top_idx;

  assign wr_idx  = IW'(sp_q);
  assign top_idx = IW'(sp_q - 1'b1);
  assign full_o  = (sp_q == SPW'(SDEPTH));
  assign empty_o = (sp_q == '0);
  assign top_o   = mem_q[top_idx];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sp_q  <= '0;
      mem_q <= '0;
    end else if (push_i && !full_o) begin
      mem_q[wr_idx] <= din_i;
      sp_q          <= sp_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_q - 1'b1;
    end
  end
endmodule

// File: rtl/cpu_stk.sv
// Single-cycle accumulator core with NREG accumulators, call/return stack,
// rdata stall handshake and sticky halt/fault status.
module cpu_stk
  import cpu_stk_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int PW     = 8,
  parameter int NREG   = 4,
  parameter int SDEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          setn,
  input  logic [31:0]   inst,
  output logic [PW-1:0] pc,
  input  logic [DW-1:0] rdata,
  input  logic          rvalid,
  output logic          write,
  output logic [DW-1:0] wdata,
  output logic [AW-1:0] addr,
  output logic          halted,
  output logic [1:0]    fault
);
  localparam int RIW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [PW-1:0]            pc_q, pc_d, pc_adv, tgt, top;
  logic [DW-1:0]            wdata_q, wdata_d, x, y, nxt_z;
  logic [AW-1:0]            addr_q, addr_d;
  logic [NREG-1:0][DW-1:0]  acc_q, acc_d;
  logic                     halted_q, halted_d;
  logic [1:0]               fault_q, fault_d;
  logic [RIW-1:0]           ridx;
  logic                     eq, lt, gt, take, commit, full, empty, push, pop;
  logic                     unused_bits;
  inst_t                    d;

  assign d           = decode(inst);
  assign unused_bits = ^{inst[31:30], inst[23:22]};
  assign ridx        = RIW'(32'(d.rsel) % NREG);

  always_comb begin
    case (d.src_x)
      SX_ACC:  x = acc_q[ridx];
      SX_ADDR: x = DW'(addr_q);
      SX_PC:   x = DW'(pc_q);
      default: x = wdata_q;
    endcase
  end
  assign y = d.src_y ? rdata : DW'($signed(d.imm));

  alu #(.MSB(DW-1)) u_alu (.x_i(x), .y_i(y), .f_i(d.fn), .z_o(nxt_z));

  assign eq     = (nxt_z == '0);
  assign lt     = nxt_z[DW-1];
  assign gt     = !eq && !lt;
  assign take   = |(d.cond & {gt, lt, eq});
  assign commit = setn && !halted_q && !(d.src_y && !rvalid);
  assign write  = rstn && d.wr && commit;
  assign pc_adv = (&pc_q) ? pc_q : pc_q + 1'b1;
  assign tgt    = PW'(nxt_z);
  assign push   = commit && (d.op == OP_CALL) && take && !full;
  assign pop    = commit && (d.op == OP_RET) && !empty;

  // Pushed return address is the saturated advance, so a CALL at the top of
  // the program space returns to itself.
  call_stack #(.PW(PW), .SDEPTH(SDEPTH)) u_stk (
    .clk(clk), .rstn(rstn), .push_i(push), .pop_i(pop), .din_i(pc_adv),
    .top_o(top), .full_o(full), .empty_o(empty)
  );

  always_comb begin
    pc_d     = pc_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    if (commit) begin
      pc_d = pc_adv;
      case (d.op)
        OP_ALU:    acc_d[ridx] = nxt_z;
        OP_ALU_WD: begin acc_d[ridx] = nxt_z; wdata_d = nxt_z; end
        OP_ALU_AD: begin acc_d[ridx] = nxt_z; addr_d = AW'(nxt_z); end
        OP_JMP:    if (take) pc_d = tgt;
        OP_CALL:   if (take) begin
                     if (full) fault_d[0] = 1'b1;
                     else      pc_d = tgt;
                   end
        OP_RET:    if (empty) fault_d[1] = 1'b1;
                   else       pc_d = top;
        OP_HALT:   begin halted_d = 1'b1; pc_d = pc_q; end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q     <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      acc_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign pc     = pc_q;
  assign wdata  = wdata_q;
  assign addr   = addr_q;
  assign halted = halted_q;
  assign fault  = fault_q;
endmodule
